// File: rtl/uart_rom_loader.sv
// UART boot loader: receives a little-endian 16-bit word count followed by
// that many little-endian 32-bit words on an 8N1 line and writes each word
// into instruction ROM through a single-cycle write port. busy holds the CPU
// in reset until the whole image is written.
module uart_rom_loader #(
  parameter int WAIT   = 868,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              frame_err
);

  localparam int CW = $clog2(WAIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(WAIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(WAIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {L_CNT_LO, L_CNT_HI, L_DATA, L_DONE} ld_state_t;

  // synchroniser stages and edge-detect history
  logic rx_p0, rx_p1, rxs_d;
  logic rxs;

  rx_state_t       rx_state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            armed;
  logic            byte_valid;
  logic [7:0]      byte_data;

  ld_state_t       ld_state;
  logic [15:0]     n;
  logic [15:0]     k;
  logic [15:0]     k_inc;
  logic [1:0]      j;
  logic [23:0]     word_lo;

  assign rxs   = rx_p1;
  assign k_inc = k + 16'd1;

  // --- stage p0/p1: two-flop synchroniser plus one history flop for edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      rx_p0 <= uart_rx;
      rx_p1 <= rx_p0;
      rxs_d <= rx_p1;
    end
  end

  // --- byte receiver: mid-bit sampling of the synchronised line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      armed      <= 1'b1;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          // after a framing error the line must be seen high before re-arming
          if (rxs) armed <= 1'b1;
          if (armed && rxs_d && !rxs) begin
            rx_state <= RX_START;
            cnt      <= '0;
            bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt      <= '0;
            rx_state <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rxs, shreg[7:1]};
            if (bit_cnt == 3'd7) rx_state <= RX_STOP;
            else                 bit_cnt  <= bit_cnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt      <= '0;
            rx_state <= RX_IDLE;
            if (rxs) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
              armed     <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // --- loader: count header, word assembly and ROM write strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_state <= L_CNT_LO;
      n        <= '0;
      k        <= '0;
      j        <= '0;
      word_lo  <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else begin
      we <= 1'b0;
      case (ld_state)
        L_CNT_LO: begin
          if (byte_valid) begin
            n[7:0]   <= byte_data;
            ld_state <= L_CNT_HI;
          end
        end
        L_CNT_HI: begin
          if (byte_valid) begin
            n[15:8] <= byte_data;
            if ({byte_data, n[7:0]} == 16'd0) begin
              ld_state <= L_DONE;
            end else begin
              ld_state <= L_DATA;
              k        <= '0;
              j        <= '0;
            end
          end
        end
        L_DATA: begin
          if (byte_valid) begin
            case (j)
              2'd0:    word_lo[7:0]   <= byte_data;
              2'd1:    word_lo[15:8]  <= byte_data;
              2'd2:    word_lo[23:16] <= byte_data;
              default: ;
            endcase
            if (j == 2'd3) begin
              // lane 3 completes the word; address wraps modulo ROM depth
              we    <= 1'b1;
              wdata <= {byte_data, word_lo};
              waddr <= k[ADDR_W-1:0];
              k     <= k_inc;
              j     <= '0;
              if (k_inc == n) ld_state <= L_DONE;
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        L_DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ld_state <= L_CNT_LO;
      endcase
    end
  end

endmodule

// File: doc/uart_rom_loader.md
Name: uart_rom_loader

Overview:
- Host-to-board boot loader on the `uart_rx` line. It receives a little-endian word count followed by that many little-endian 32-bit words, and writes each word into instruction ROM through a single-cycle write port.
- It sits in `mother_board` between the `uart_rx` pin and the ROM write side. `busy` holds the CPU in reset until the image is loaded.
- It is the inbound counterpart to the CPU's ROM fetch path and to the board's UART transmitter.

Parameters:
- WAIT, 868: clock cycles per UART bit (CLOCK_HZ/UART_BAUD_RATE). Must be ≥ 4.
- ADDR_W, 10: ROM word-address width.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- uart_rx  input  1  serial in, idle high, 8N1, LSB first.
- we  output  1  ROM write strobe, one-cycle pulse.
- waddr  output  ADDR_W  ROM word address for the current write.
- wdata  output  32  ROM write data.
- busy  output  1  load not yet complete; CPU held in reset while 1.
- done  output  1  sticky; image fully written.
- frame_err  output  1  sticky; at least one byte had stop bit = 0.

Behaviour:
- Reset values (all asynchronous): we=0, waddr=0, wdata=0, busy=1, done=0, frame_err=0. Synchroniser flops = 1. All counters = 0. Both FSMs in their first state.
- Input sync: `uart_rx` passes through 2 flops. All decisions use the synchronised value `rxs`.
- Byte receiver FSM: states IDLE, START, DATA, STOP.
  - IDLE: a falling edge on `rxs` → START, bit counter cleared to 0.
  - START: wait WAIT/2 (integer divide) cycles, then sample. `rxs`=1 → false start, back to IDLE. `rxs`=0 → DATA.
  - DATA: sample every WAIT cycles, 8 samples, shift in LSB first. After the 8th sample → STOP.
  - STOP: sample WAIT cycles after the last data bit.
    - `rxs`=1: raise `byte_valid` for 1 cycle with the assembled byte.
    - `rxs`=0: byte dropped, frame_err←1. The receiver does not re-arm until `rxs` has been seen high.
  - After STOP, return to IDLE immediately; the receiver does not wait out the stop bit.
- Loader FSM: states CNT_LO, CNT_HI, DATA, DONE. It advances only on `byte_valid`.
  - CNT_LO: byte → N[7:0].
  - CNT_HI: byte → N[15:8].
    - If N==0: → DONE.
    - Otherwise: → DATA with word index k=0 and byte index j=0.
  - DATA: byte j is placed in lane j of the word (j=0 → bits [7:0], j=3 → bits [31:24]).
    - On j==3, in the cycle after `byte_valid`: we=1, wdata = the full word, waddr = k[ADDR_W-1:0].
    - we stays 1 for exactly 1 cycle. waddr and wdata hold their value until the next write.
    - Then k←k+1 and j←0. When k reaches N → DONE.
  - DONE: busy=0, done=1. Both are sticky until reset; all further bytes are ignored and we stays 0.
- Width/wrap rules:
  - k and N are 16-bit.
  - waddr is k modulo 2^ADDR_W. If N > 2^ADDR_W, later words overwrite earlier ones; no error is flagged.
- Latency: we rises exactly 1 cycle after the `byte_valid` of byte 3. That is 2 cycles after the stop-bit sample, counting the sync delay separately.
- Reset mid-byte or mid-image: everything returns to reset values. The host must restart from the count header. A partially assembled word is never written.
- Simultaneous events: a falling edge arriving in the same cycle as the STOP sample is not detected. The next start bit must begin at least 1 cycle after the stop sample; 8N1 timing guarantees this.

Test Plan (use WAIT=16, ADDR_W=4):
- Reset hold:
  - reset=0 with `uart_rx` toggling → we=0, busy=1, done=0, frame_err=0 throughout.
  - After release with idle line: no we for 10,000 cycles.
- Single word:
  - Send bytes 01 00 01 11 31 54 → exactly one we pulse, waddr=0, wdata=32'h54311101.
  - Then busy=0 and done=1 on the following cycle.
- Multi-word and wrap:
  - N=17, words 32'h0000_0000 … 32'h0000_0010 → 17 we pulses.
  - waddr sequence 0…15, 0; the last pulse has wdata=32'h10 at waddr=0.
  - done=1 after the 17th pulse.
- Zero count: bytes 00 00 → no we pulse, done=1 after the second byte's stop sample. A later byte AA produces no we.
- Glitch and framing:
  - A 3-cycle low pulse on idle `uart_rx` → false start, no byte accepted.
  - A byte sent with stop bit=0 → frame_err=1 and the byte is not counted.
  - A subsequent valid header and word still load correctly.
- Reset mid-image:
  - Assert reset after 2 of 4 data bytes → outputs return to reset values.
  - A fresh full image then loads, with the first write at waddr=0.
